lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Serial receive-side checker for the team's 16-bit Fibonacci LFSR pattern generator.
- Generator polynomial: feedback = s[15]^s[13]^s[12]^s[10], shifted into bit 0.
- Consumes one pattern bit per valid cycle (the generator's newest bit, out[0]).
- Self-seeds from the stream, declares lock, then counts bit errors against a local reference LFSR and drops lock on excessive errors. Used for link/BER bring-up.

Parameters:
- LOCK_CNT, 32: consecutive matching bits in VERIFY required to declare lock (1..255).
- ERR_THRESH, 4: errors within one window that force loss of lock (1..WINDOW).
- WINDOW, 64: window length in valid bits while LOCKED (power of two, 2..1024).
- CNT_W, 16: width of the saturating error counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- nReset  in  1  reset, synchronous, active-high; clock clk.
- din  in  1  received pattern bit.
- din_valid  in  1  din is sampled on this posedge.
- clr_cnt  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED.
- bit_err  out  1  one-cycle pulse: the previous valid bit mismatched while LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_count  out  CNT_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset (nReset=1 at posedge):
  - state=HUNT; shadow register, fill counter, match counter, window counters = 0.
  - locked, bit_err, lock_lost, err_count = 0.
  - Reset wins over all other inputs, including mid-lock.
- Cycles with din_valid=0: no state or counter changes. bit_err and lock_lost return to 0.
- Definitions: shadow s[15:0]; pred = s[15]^s[13]^s[12]^s[10]; mismatch = din_valid & (din != pred).
- HUNT:
  - Each valid bit: s <= {s[14:0],din}; fill++.
  - On the 16th valid bit:
    - If the new s != 0: go to VERIFY, match counter = 0.
    - Else (all-zero seed is a lockup state): fill=0, stay in HUNT.
- VERIFY:
  - Each valid bit: s <= {s[14:0],din}.
  - On a match: match++. When match reaches LOCK_CNT, go to LOCKED; locked=1 on the following cycle.
  - On a mismatch: go to HUNT with fill=1 (this bit is the first fill bit). No errors are counted.
- LOCKED:
  - Each valid bit: s <= {s[14:0],pred}. The reference free-runs, so a single line error yields exactly one bit_err.
  - Mismatch: bit_err=1 next cycle; err_count++ (saturates at all-ones); win_err++.
  - Window: win_bits counts valid bits 0..WINDOW-1. On the valid bit that wraps it to 0, win_err restarts. A mismatch on that same bit counts as 1 in the new window.
  - If a mismatch makes win_err reach ERR_THRESH:
    - next state HUNT, fill=0, locked=0, lock_lost=1 for one cycle.
    - bit_err is also 1 that cycle; err_count keeps its value.
- clr_cnt:
  - Alone: err_count <= 0.
  - Same cycle as a counted mismatch: err_count <= 1 (clear, then count).
  - Does not affect state or window counters.
- All outputs are registered. Latency from the sampled din edge to the locked, bit_err or lock_lost change: 1 cycle.
- Lock acquisition from reset with a clean stream: locked rises the cycle after valid bit 16+LOCK_CNT (48 by default).

Optional Feature:
- LFSR_CHK_BITCNT_EN defined:
  - adds output bit_count[31:0], counting valid bits compared while LOCKED; saturates at 32'hFFFF_FFFF.
  - cleared by reset and by clr_cnt (clear-then-count, same rule as err_count).
  - Gives a BER denominator.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=16 and the tap positions (15,13,12,10), shared with the generator.
  - state enum chk_state_t {HUNT, VERIFY, LOCKED}.
  - function lfsr_fb(logic [15:0]) returning the feedback bit.
- One natural sub-module: sat_counter (parameterised width, inc, clr), instanced for err_count and for bit_count when enabled.

Test Plan:
- Generator seeded 16'hACE1, out[0] fed every cycle with din_valid=1 -> locked rises the cycle after bit 48; err_count=0 after 1000 bits.
- Locked; flip one bit at bit index 200 -> single bit_err pulse one cycle later; err_count=1; locked stays 1.
- Locked; flip 4 bits within 64 bits -> lock_lost pulse with 4th bit_err; locked=0; relock 48 valid bits later; err_count=4.
- Constant din=0 for 500 bits -> never leaves HUNT, locked=0. din_valid toggling 50% on a clean stream -> lock after 48 valid bits, not 48 cycles.
- err_count=5 with clr_cnt and a mismatch in the same cycle -> err_count=1. CNT_W=4 with 20 spaced errors -> saturates at 15.
- nReset pulsed while LOCKED with err_count=3 -> next cycle all outputs 0, state HUNT; relock needs a full 48 bits.

Source files
------------

// File: rtl/lfsr_checker_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR pattern generator and checker.
// The tap positions here match the generator, so both sides derive the same sequence.
package lfsr_pkg;

  localparam int LFSR_W = 16;
  localparam int TAP0   = 15;
  localparam int TAP1   = 13;
  localparam int TAP2   = 12;
  localparam int TAP3   = 10;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Feedback bit that gets shifted into bit 0 on the next step.
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
  endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear. When clear and increment
// arrive in the same cycle, the clear happens first and the event is still counted.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  // Count up and stop at all-ones; a clear restarts the count from this cycle's event.
  always_ff @(posedge clk) begin
    if (nReset) begin
      o_count <= '0;
    end else if (i_clr) begin
      o_count <= i_inc ? W'(1) : '0;
    end else if (i_inc && !(&o_count)) begin
      o_count <= o_count + W'(1);
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// Serial receive-side checker for the 16-bit Fibonacci LFSR pattern.
// The checker seeds itself from the incoming stream, confirms the seed over LOCK_CNT
// bits, and then lets the reference free-run while it counts bit errors.
// Optional build macro LFSR_CHK_BITCNT_EN adds bit_count, which counts bits
// compared while locked and serves as the denominator for a BER estimate.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 32,
  parameter int ERR_THRESH = 4,
  parameter int WINDOW     = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             bit_err,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_BITCNT_EN
  ,
  output logic [31:0]      bit_count
`endif
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int ERR_W = $clog2(WINDOW + 1);

  chk_state_t        r_state, w_nextState;
  logic [LFSR_W-1:0] r_shadow, w_nextShadow, w_shiftIn;
  logic [4:0]        r_fill, w_nextFill;
  logic [7:0]        r_match, w_nextMatch;
  logic [WIN_W-1:0]  r_winBits, w_nextWinBits;
  logic [ERR_W-1:0]  r_winErr, w_nextWinErr, w_winBase;
  logic              r_locked, r_bitErr, r_lockLost;
  logic              w_pred, w_mismatch, w_errInc, w_nextBitErr, w_nextLockLost;
  logic              w_cmpLocked;

  assign w_pred      = lfsr_fb(r_shadow);
  assign w_mismatch  = din_valid && (din != w_pred);
  assign w_shiftIn   = {r_shadow[LFSR_W-2:0], din};
  assign w_cmpLocked = din_valid && (r_state == LOCKED);

  // Next-state and next-counter logic for the HUNT/VERIFY/LOCKED sequence.
  always_comb begin
    w_nextState    = r_state;
    w_nextShadow   = r_shadow;
    w_nextFill     = r_fill;
    w_nextMatch    = r_match;
    w_nextWinBits  = r_winBits;
    w_nextWinErr   = r_winErr;
    w_winBase      = r_winErr;
    w_errInc       = 1'b0;
    w_nextBitErr   = 1'b0;
    w_nextLockLost = 1'b0;
    if (din_valid) begin
      case (r_state)
        HUNT: begin
          w_nextShadow = w_shiftIn;
          if (r_fill == 5'd15) begin
            w_nextFill = 5'd0;
            if (w_shiftIn != '0) begin
              w_nextState = VERIFY;
              w_nextMatch = 8'd0;
            end
          end else begin
            w_nextFill = r_fill + 5'd1;
          end
        end
        VERIFY: begin
          w_nextShadow = w_shiftIn;
          if (w_mismatch) begin
            w_nextState = HUNT;
            w_nextFill  = 5'd1;
          end else if (r_match == 8'(LOCK_CNT - 1)) begin
            w_nextState   = LOCKED;
            w_nextWinBits = '0;
            w_nextWinErr  = '0;
          end else begin
            w_nextMatch = r_match + 8'd1;
          end
        end
        LOCKED: begin
          w_nextShadow  = {r_shadow[LFSR_W-2:0], w_pred};
          w_nextWinBits = r_winBits + WIN_W'(1);
          w_winBase     = (r_winBits == WIN_W'(WINDOW - 1)) ? '0 : r_winErr;
          w_nextWinErr  = w_winBase;
          if (w_mismatch) begin
            w_errInc     = 1'b1;
            w_nextBitErr = 1'b1;
            w_nextWinErr = w_winBase + ERR_W'(1);
            if (w_winBase + ERR_W'(1) >= ERR_W'(ERR_THRESH)) begin
              w_nextState    = HUNT;
              w_nextFill     = 5'd0;
              w_nextLockLost = 1'b1;
            end
          end
        end
        default: begin
          w_nextState = HUNT;
          w_nextFill  = 5'd0;
        end
      endcase
    end
  end

  // Register state, counters and the status outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (nReset) begin
      r_state    <= HUNT;
      r_shadow   <= '0;
      r_fill     <= '0;
      r_match    <= '0;
      r_winBits  <= '0;
      r_winErr   <= '0;
      r_locked   <= 1'b0;
      r_bitErr   <= 1'b0;
      r_lockLost <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_shadow   <= w_nextShadow;
      r_fill     <= w_nextFill;
      r_match    <= w_nextMatch;
      r_winBits  <= w_nextWinBits;
      r_winErr   <= w_nextWinErr;
      r_locked   <= (w_nextState == LOCKED);
      r_bitErr   <= w_nextBitErr;
      r_lockLost <= w_nextLockLost;
    end
  end

  assign locked    = r_locked;
  assign bit_err   = r_bitErr;
  assign lock_lost = r_lockLost;

  sat_counter #(.W(CNT_W)) u_errCnt (
    .clk     (clk),
    .nReset  (nReset),
    .i_inc   (w_errInc),
    .i_clr   (clr_cnt),
    .o_count (err_count)
  );

`ifdef LFSR_CHK_BITCNT_EN
  sat_counter #(.W(32)) u_bitCnt (
    .clk     (clk),
    .nReset  (nReset),
    .i_inc   (w_cmpLocked),
    .i_clr   (clr_cnt),
    .o_count (bit_count)
  );
`else
  // Without the bit counter, the locked-compare strobe has no consumer.
  logic w_unusedCmp;
  assign w_unusedCmp = w_cmpLocked;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock acquisition, single and burst errors,
// counter clear/saturation, reset while locked, gapped valid and all-zero input.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        nReset, din, din_valid, clr_cnt;
  logic        locked, bit_err, lock_lost;
  logic [15:0] err_count;
  logic        locked4, bitErr4, lockLost4;
  logic [3:0]  errCount4;
`ifdef LFSR_CHK_BITCNT_EN
  logic [31:0] bit_count, bitCount4;
`endif

  int          nChecks = 0;
  int          nPass   = 0;
  int          bitErrSeen, lockedSeen;
  logic [15:0] gen;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk       (clk),
    .nReset    (nReset),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .bit_err   (bit_err),
    .lock_lost (lock_lost),
    .err_count (err_count)
`ifdef LFSR_CHK_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  lfsr_checker #(.CNT_W(4)) dut4 (
    .clk       (clk),
    .nReset    (nReset),
    .din       (din),
    .din_valid (din_valid),
    .clr_cnt   (clr_cnt),
    .locked    (locked4),
    .bit_err   (bitErr4),
    .lock_lost (lockLost4),
    .err_count (errCount4)
`ifdef LFSR_CHK_BITCNT_EN
    ,
    .bit_count (bitCount4)
`endif
  );

  function automatic logic modelFb(input logic [15:0] s);
    return s[15] ^ s[13] ^ s[12] ^ s[10];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Drive one cycle of inputs on the falling edge, sample just after the rising edge.
  task automatic applyStimulus(input logic b, input logic v, input logic clr);
    @(negedge clk);
    din       = b;
    din_valid = v;
    clr_cnt   = clr;
    @(posedge clk);
    #1;
    if (bit_err === 1'b1) bitErrSeen++;
    if (locked === 1'b1) lockedSeen++;
  endtask

  task automatic sendGen(input logic flip, input logic clr);
    gen = {gen[14:0], modelFb(gen)};
    applyStimulus(gen[0] ^ flip, 1'b1, clr);
  endtask

  task automatic sendClean(input int n);
    repeat (n) sendGen(1'b0, 1'b0);
  endtask

  task automatic doReset();
    nReset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    nReset = 1'b0;
  endtask

  initial begin
    nReset = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
    gen = 16'hACE1; bitErrSeen = 0; lockedSeen = 0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    nReset = 1'b0;
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_bit_err", 32'(bit_err), 32'd0);
    checkOutput("rst_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("rst_err_count", 32'(err_count), 32'd0);

    // Clean stream: lock after bit 48, no errors up to bit 1000.
    sendClean(47);
    checkOutput("locked_after_47", 32'(locked), 32'd0);
    sendClean(1);
    checkOutput("locked_after_48", 32'(locked), 32'd1);
    bitErrSeen = 0;
    sendClean(952);
    checkOutput("clean_err_count", 32'(err_count), 32'd0);
    checkOutput("clean_bit_err_pulses", 32'(bitErrSeen), 32'd0);
    checkOutput("clean_locked", 32'(locked), 32'd1);
`ifdef LFSR_CHK_BITCNT_EN
    checkOutput("clean_bit_count", bit_count, 32'd952);
`endif

    // Single flipped bit at stream bit 1028.
    sendClean(27);
    sendGen(1'b1, 1'b0);
    checkOutput("single_bit_err", 32'(bit_err), 32'd1);
    checkOutput("single_err_count", 32'(err_count), 32'd1);
    checkOutput("single_locked", 32'(locked), 32'd1);
    sendGen(1'b0, 1'b0);
    checkOutput("single_pulse_end", 32'(bit_err), 32'd0);

    // Four errors inside one window (bits 1078/1083/1088/1093) drop lock.
    sendClean(48);
    sendGen(1'b1, 1'b0);
    checkOutput("burst1_bit_err", 32'(bit_err), 32'd1);
    sendClean(4);
    sendGen(1'b1, 1'b0);
    sendClean(4);
    sendGen(1'b1, 1'b0);
    checkOutput("burst3_locked", 32'(locked), 32'd1);
    checkOutput("burst3_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("burst3_err_count", 32'(err_count), 32'd4);
    sendClean(4);
    sendGen(1'b1, 1'b0);
    checkOutput("burst4_lock_lost", 32'(lock_lost), 32'd1);
    checkOutput("burst4_bit_err", 32'(bit_err), 32'd1);
    checkOutput("burst4_locked", 32'(locked), 32'd0);
    checkOutput("burst4_err_count", 32'(err_count), 32'd5);
`ifdef LFSR_CHK_BITCNT_EN
    checkOutput("burst4_bit_count", bit_count, 32'd1045);
`endif
    sendGen(1'b0, 1'b0);
    checkOutput("lock_lost_pulse_end", 32'(lock_lost), 32'd0);
    sendClean(46);
    checkOutput("relock_after_47", 32'(locked), 32'd0);
    sendClean(1);
    checkOutput("relock_after_48", 32'(locked), 32'd1);

    // Clear together with a counted mismatch, then clear alone on an idle cycle.
    sendGen(1'b1, 1'b1);
    checkOutput("clr_with_err", 32'(err_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr_alone", 32'(err_count), 32'd0);
    checkOutput("idle_bit_err", 32'(bit_err), 32'd0);
`ifdef LFSR_CHK_BITCNT_EN
    checkOutput("clr_bit_count", bit_count, 32'd0);
`endif

    // Twenty widely spaced errors: 16-bit counter reaches 20, 4-bit counter sticks at 15.
    repeat (20) begin
      sendClean(69);
      sendGen(1'b1, 1'b0);
    end
    checkOutput("spaced_err_count", 32'(err_count), 32'd20);
    checkOutput("sat4_err_count", 32'(errCount4), 32'd15);
    checkOutput("spaced_locked", 32'(locked), 32'd1);

    // Reset while locked, with a bad bit and clr on the same edge.
    doReset();
    checkOutput("midrst_locked", 32'(locked), 32'd0);
    checkOutput("midrst_bit_err", 32'(bit_err), 32'd0);
    checkOutput("midrst_lock_lost", 32'(lock_lost), 32'd0);
    checkOutput("midrst_err_count", 32'(err_count), 32'd0);
    checkOutput("midrst_err_count4", 32'(errCount4), 32'd0);

    // Valid on every other cycle: lock counts valid bits, not cycles.
    for (int i = 1; i <= 48; i++) begin
      sendGen(1'b0, 1'b0);
      if (i == 47) checkOutput("gapped_locked_47", 32'(locked), 32'd0);
      if (i == 48) checkOutput("gapped_locked_48", 32'(locked), 32'd1);
      applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    checkOutput("gapped_err_count", 32'(err_count), 32'd0);

    // All-zero input never seeds the checker.
    doReset();
    lockedSeen = 0;
    bitErrSeen = 0;
    repeat (500) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("zeros_locked_cycles", 32'(lockedSeen), 32'd0);
    checkOutput("zeros_bit_err_pulses", 32'(bitErrSeen), 32'd0);
    checkOutput("zeros_err_count", 32'(err_count), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
